mc_control_fsm: RTL and testbench



---
 rtl/mc_control_fsm.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit.
//
// Walks every instruction through FETCH -> DECODE -> EXEC -> MEM -> WB and
// drives per-state datapath strobes. The memory occupies MEM_LAT cycles per
// access, counted by a small wait counter during FETCH and MEM. SYSCALL parks
// the unit in HALT until 'go'. Unknown opcodes/funcs pulse 'illegal' and are
// retired as NOPs.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   op, func          IR[31:26], IR[5:0] (valid from DECODE onward)
//   eq, gtz           branch conditions from the regfile compare
//   go                resume from HALT
//   pc_write/pc_src   PC load strobe and source (0 PC+4, 1 branch, 2 jump, 3 rs)
//   ir_write          IR load strobe
//   mem_read/mem_write/mem_mode  memory controls (mode 01 half, 10 word)
//   alu_src/signed_ext/shift_var/alu_op  ALU operand and function controls
//   reg_write/reg_dst/mem_to_reg/link    regfile write controls
//   halt, illegal     status
//   state             current FSM state for debug
//
// Handshake: there is none in the valid/ready sense. Memory is assumed to
// complete exactly MEM_LAT cycles after mem_read/mem_write first rise; the
// strobes stay up for all of those cycles.
module mc_control_fsm #(
  parameter int MEM_LAT  = 1,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                eq,
  input  logic                gtz,
  input  logic                go,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          mem_mode,
  output logic                alu_src,
  output logic                signed_ext,
  output logic                shift_var,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                link,
  output logic                halt,
  output logic                illegal,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------
  // Instruction decode (pure function of op/func)
  // ---------------------------------------------------------------------
  logic                is_rtype, is_bad;
  logic                is_j, is_jal, is_jr, is_sys;
  logic                is_beq, is_bne, is_bgtz;
  logic                is_lw, is_sw, is_sh;
  logic                dec_imm, dec_sext, dec_svar;
  logic [ALU_OP_W-1:0] dec_alu;

  assign is_rtype = (op == 6'd0);

  always_comb begin
    is_bad   = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    is_sys   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_bgtz  = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_sh    = 1'b0;
    dec_imm  = 1'b0;
    dec_sext = 1'b0;
    dec_svar = 1'b0;
    dec_alu  = ALU_OP_W'(13);
    case (op)
      6'd0: begin
        case (func)
          6'd0:  dec_alu = ALU_OP_W'(0);              // SLL
          6'd2:  dec_alu = ALU_OP_W'(2);              // SRL
          6'd3:  dec_alu = ALU_OP_W'(1);              // SRA
          6'd4: begin                                 // SLLV
            dec_alu  = ALU_OP_W'(0);
            dec_svar = 1'b1;
          end
          6'd8:  is_jr   = 1'b1;                      // JR
          6'd12: is_sys  = 1'b1;                      // SYSCALL
          6'd32, 6'd33: dec_alu = ALU_OP_W'(5);       // ADD, ADDU
          6'd34: dec_alu = ALU_OP_W'(6);              // SUB
          6'd36: dec_alu = ALU_OP_W'(7);              // AND
          6'd37: dec_alu = ALU_OP_W'(8);              // OR
          6'd39: dec_alu = ALU_OP_W'(10);             // NOR
          6'd42: dec_alu = ALU_OP_W'(11);             // SLT
          6'd43: dec_alu = ALU_OP_W'(12);             // SLTU
          default: is_bad = 1'b1;
        endcase
      end
      6'd2:  is_j    = 1'b1;
      6'd3:  is_jal  = 1'b1;
      6'd4:  is_beq  = 1'b1;
      6'd5:  is_bne  = 1'b1;
      6'd7:  is_bgtz = 1'b1;
      6'd8, 6'd9: begin                               // ADDI, ADDIU
        dec_alu  = ALU_OP_W'(5);
        dec_imm  = 1'b1;
        dec_sext = 1'b1;
      end
      6'd10: begin                                    // SLTI
        dec_alu  = ALU_OP_W'(11);
        dec_imm  = 1'b1;
        dec_sext = 1'b1;
      end
      6'd11: begin                                    // SLTIU
        dec_alu = ALU_OP_W'(12);
        dec_imm = 1'b1;
      end
      6'd12: begin                                    // ANDI
        dec_alu = ALU_OP_W'(7);
        dec_imm = 1'b1;
      end
      6'd13: begin                                    // ORI
        dec_alu = ALU_OP_W'(8);
        dec_imm = 1'b1;
      end
      6'd35, 6'd41, 6'd43: begin                      // LW, SH, SW
        is_lw    = (op == 6'd35);
        is_sh    = (op == 6'd41);
        is_sw    = (op == 6'd43);
        dec_alu  = ALU_OP_W'(5);
        dec_imm  = 1'b1;
        dec_sext = 1'b1;
      end
      default: is_bad = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and wait counter registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and strobes
  // ---------------------------------------------------------------------
  logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c;
  logic       reg_write_c, reg_dst_c, mem_to_reg_c, link_c, halt_c, illegal_c;
  logic [1:0] pc_src_c, mem_mode_c;
  logic       alu_hold;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    pc_write_c   = 1'b0;
    pc_src_c     = 2'd0;
    ir_write_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_mode_c   = 2'b00;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    link_c       = 1'b0;
    halt_c       = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        mem_mode_c = 2'b10;
        if (cnt_last) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        if (is_bad) begin
          illegal_c = 1'b1;
          state_d   = S_FETCH;
        end else if (is_j || is_jal) begin
          pc_write_c  = 1'b1;
          pc_src_c    = 2'd2;
          reg_write_c = is_jal;
          link_c      = is_jal;
          state_d     = S_FETCH;
        end else if (is_jr) begin
          pc_write_c = 1'b1;
          pc_src_c   = 2'd3;
          state_d    = S_FETCH;
        end else if (is_sys) begin
          state_d = S_HALT;
        end
      end
      S_EXEC: begin
        if (is_beq || is_bne || is_bgtz) begin
          pc_src_c   = 2'd1;
          pc_write_c = (is_beq & eq) | (is_bne & ~eq) | (is_bgtz & gtz);
          state_d    = S_FETCH;
        end else if (is_lw || is_sw || is_sh) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read_c  = is_lw;
        mem_write_c = is_sw | is_sh;
        mem_mode_c  = is_sh ? 2'b01 : 2'b10;
        if (cnt_last) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = is_rtype;
        mem_to_reg_c = is_lw;
        state_d      = S_FETCH;
      end
      S_HALT: begin
        halt_c = 1'b1;
        if (go) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;   // unused codes 6/7 recover
    endcase
  end

  // ALU controls stay valid from EXEC through WB so the memory address and
  // writeback result do not move while the access is in flight.
  assign alu_hold = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  // Everything is forced low while reset is asserted, even mid-access.
  assign pc_write   = pc_write_c   & ~rst;
  assign pc_src     = rst ? 2'd0 : pc_src_c;
  assign ir_write   = ir_write_c   & ~rst;
  assign mem_read   = mem_read_c   & ~rst;
  assign mem_write  = mem_write_c  & ~rst;
  assign mem_mode   = rst ? 2'd0 : mem_mode_c;
  assign alu_src    = alu_hold & dec_imm  & ~rst;
  assign signed_ext = alu_hold & dec_sext & ~rst;
  assign shift_var  = alu_hold & dec_svar & ~rst;
  assign alu_op     = (alu_hold && !rst) ? dec_alu : '0;
  assign reg_write  = reg_write_c  & ~rst;
  assign reg_dst    = reg_dst_c    & ~rst;
  assign mem_to_reg = mem_to_reg_c & ~rst;
  assign link       = link_c       & ~rst;
  assign halt       = halt_c       & ~rst;
  assign illegal    = illegal_c    & ~rst;
  assign state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm. Two instances share inputs: one with MEM_LAT=1,
// one with MEM_LAT=3. Only one instance is checked at a time; both are reset
// before switching. The reference model expands an instruction into its
// expected per-cycle output trace from an ISA table.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_mode;
    logic       alu_src;
    logic       signed_ext;
    logic       shift_var;
    logic [3:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       link;
    logic       halt;
    logic       illegal;
    logic [2:0] state;
  } out_t;

  typedef enum {C_RALU, C_IALU, C_LW, C_SW, C_SH, C_BEQ, C_BNE, C_BGTZ,
                C_J, C_JAL, C_JR, C_SYS, C_ILL} cls_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    cls_e       cls;
    logic [3:0] alu;
    logic       src;
    logic       sext;
    logic       svar;
  } isa_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] func;
    logic       eq;
    logic       gtz;
    int         cycles;
    logic [3:0] alu;
    logic       pcw;
    logic       rw;
    logic       mw;
    logic       ill;
    logic [1:0] mm;
  } vec_t;

  localparam int ISA_N = 28;
  localparam int VEC_N = 18;

  // clock / reset / DUT signals
  logic clk = 1'b0;
  logic rst;
  logic [5:0] op, func;
  logic eq, gtz, go;

  logic a_pc_write, a_ir_write, a_mem_read, a_mem_write, a_alu_src, a_signed_ext, a_shift_var;
  logic a_reg_write, a_reg_dst, a_mem_to_reg, a_link, a_halt, a_illegal;
  logic [1:0] a_pc_src, a_mem_mode;
  logic [3:0] a_alu_op;
  logic [2:0] a_state;
  logic b_pc_write, b_ir_write, b_mem_read, b_mem_write, b_alu_src, b_signed_ext, b_shift_var;
  logic b_reg_write, b_reg_dst, b_mem_to_reg, b_link, b_halt, b_illegal;
  logic [1:0] b_pc_src, b_mem_mode;
  logic [3:0] b_alu_op;
  logic [2:0] b_state;

  out_t obs_a, obs_b;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_LAT(1), .ALU_OP_W(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .op(op), .func(func), .eq(eq), .gtz(gtz), .go(go),
    .pc_write(a_pc_write), .pc_src(a_pc_src), .ir_write(a_ir_write),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_mode(a_mem_mode),
    .alu_src(a_alu_src), .signed_ext(a_signed_ext), .shift_var(a_shift_var),
    .alu_op(a_alu_op), .reg_write(a_reg_write), .reg_dst(a_reg_dst),
    .mem_to_reg(a_mem_to_reg), .link(a_link), .halt(a_halt),
    .illegal(a_illegal), .state(a_state)
  );

  mc_control_fsm #(.MEM_LAT(3), .ALU_OP_W(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .op(op), .func(func), .eq(eq), .gtz(gtz), .go(go),
    .pc_write(b_pc_write), .pc_src(b_pc_src), .ir_write(b_ir_write),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_mode(b_mem_mode),
    .alu_src(b_alu_src), .signed_ext(b_signed_ext), .shift_var(b_shift_var),
    .alu_op(b_alu_op), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
    .mem_to_reg(b_mem_to_reg), .link(b_link), .halt(b_halt),
    .illegal(b_illegal), .state(b_state)
  );

  assign obs_a = {a_pc_write, a_pc_src, a_ir_write, a_mem_read, a_mem_write, a_mem_mode,
                  a_alu_src, a_signed_ext, a_shift_var, a_alu_op, a_reg_write, a_reg_dst,
                  a_mem_to_reg, a_link, a_halt, a_illegal, a_state};
  assign obs_b = {b_pc_write, b_pc_src, b_ir_write, b_mem_read, b_mem_write, b_mem_mode,
                  b_alu_src, b_signed_ext, b_shift_var, b_alu_op, b_reg_write, b_reg_dst,
                  b_mem_to_reg, b_link, b_halt, b_illegal, b_state};

  // scoreboard
  logic [23:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  isa_t isa[ISA_N];
  vec_t vt[VEC_N];

  function automatic out_t obs(input int lat);
    return (lat == 1) ? obs_a : obs_b;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  function automatic int lookup(input logic [5:0] o, input logic [5:0] f);
    for (int i = 0; i < ISA_N; i++)
      if (isa[i].op == o && (o != 6'd0 || isa[i].func == f)) return i;
    return -1;
  endfunction

  function automatic cls_e cls_of(input logic [5:0] o, input logic [5:0] f);
    int k;
    k = lookup(o, f);
    return (k < 0) ? C_ILL : isa[k].cls;
  endfunction

  // Expected output for every cycle from the first FETCH cycle up to the last
  // cycle of the instruction (DECODE for SYSCALL; HALT is handled separately).
  function automatic void build(input logic [5:0] o, input logic [5:0] f,
                                input logic e, input logic g, input int lat);
    out_t c, m;
    int   k;
    cls_e cl;
    exp_q.delete();
    k  = lookup(o, f);
    cl = (k < 0) ? C_ILL : isa[k].cls;
    for (int i = 0; i < lat; i++) begin
      c = '0;
      c.mem_read = 1'b1;
      c.mem_mode = 2'b10;
      if (i == lat - 1) begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
      end
      exp_q.push_back(c);
    end
    c = '0;
    c.state = 3'd1;
    if (cl == C_J || cl == C_JAL || cl == C_JR) begin
      c.pc_write = 1'b1;
      c.pc_src   = (cl == C_JR) ? 2'd3 : 2'd2;
      c.reg_write = (cl == C_JAL);
      c.link      = (cl == C_JAL);
    end
    if (cl == C_ILL) c.illegal = 1'b1;
    exp_q.push_back(c);
    if (cl == C_J || cl == C_JAL || cl == C_JR || cl == C_ILL || cl == C_SYS) return;
    c = '0;
    c.alu_op     = isa[k].alu;
    c.alu_src    = isa[k].src;
    c.signed_ext = isa[k].sext;
    c.shift_var  = isa[k].svar;
    m = c;
    m.state = 3'd2;
    if (cl == C_BEQ || cl == C_BNE || cl == C_BGTZ) begin
      m.pc_src   = 2'd1;
      m.pc_write = (cl == C_BEQ) ? e : (cl == C_BNE) ? !e : g;
      exp_q.push_back(m);
      return;
    end
    exp_q.push_back(m);
    if (cl == C_LW || cl == C_SW || cl == C_SH) begin
      for (int i = 0; i < lat; i++) begin
        m = c;
        m.state     = 3'd3;
        m.mem_read  = (cl == C_LW);
        m.mem_write = (cl != C_LW);
        m.mem_mode  = (cl == C_SH) ? 2'b01 : 2'b10;
        exp_q.push_back(m);
      end
      if (cl != C_LW) return;
    end
    m = c;
    m.state      = 3'd4;
    m.reg_write  = 1'b1;
    m.reg_dst    = (cl == C_RALU);
    m.mem_to_reg = (cl == C_LW);
    exp_q.push_back(m);
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks. Each starts and ends at a sample point inside the first
  // FETCH cycle of an instruction (or in HALT after a SYSCALL).
  // ---------------------------------------------------------------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    op = '0; func = '0; eq = 1'b0; gtz = 1'b0; go = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check("reset_outs_a", obs_a, 24'd0);
      check("reset_outs_b", obs_b, 24'd0);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic run_trace(input string name, input int lat);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      check(name, obs(lat), exp_q[i]);
    end
    tick();
  endtask

  task automatic do_halt(input int n);
    out_t h;
    h = '0;
    h.halt  = 1'b1;
    h.state = 3'd5;
    go = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("halt_wait", obs_a, h);
      tick();
    end
    go = 1'b1;
    check("halt_go", obs_a, h);
    tick();
    go = 1'b0;
    check("halt_exit_state", 24'(obs_a.state), 24'd0);
  endtask

  task automatic run_count(input vec_t v, input int lat, input string name);
    int   cyc;
    logic left, pcw, rw, mw, ill;
    logic [3:0] alu;
    logic [1:0] mm;
    out_t o;
    op = v.op; func = v.func; eq = v.eq; gtz = v.gtz;
    #1;
    cyc = 1; left = 0; pcw = 0; rw = 0; mw = 0; ill = 0; alu = '0; mm = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      o = obs(lat);
      if (o.state == 3'd0 && left) break;
      cyc++;
      if (o.state != 3'd0) begin
        left = 1'b1;
        pcw |= o.pc_write;
        rw  |= o.reg_write;
        mw  |= o.mem_write;
        ill |= o.illegal;
        if (o.state == 3'd2) alu = o.alu_op;
        if (o.state == 3'd3) mm  = o.mem_mode;
      end
    end
    check({name, "_cycles"}, 24'(cyc), 24'(v.cycles));
    check({name, "_flags"}, {15'd0, alu, pcw, rw, mw, ill, mm},
          {15'd0, v.alu, v.pcw, v.rw, v.mw, v.ill, v.mm});
  endtask

  task automatic random_run(input int n, input int lat);
    logic [5:0] o, f;
    int k;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        k = $urandom_range(0, ISA_N - 1);
        o = isa[k].op;
        f = (o == 6'd0) ? isa[k].func : 6'($urandom);
      end else begin
        o = 6'($urandom);
        f = 6'($urandom);
      end
      op = o; func = f; eq = 1'($urandom); gtz = 1'($urandom);
      go = 1'($urandom);   // go must be ignored outside HALT
      build(o, f, eq, gtz, lat);
      run_trace(lat == 1 ? "rand_lat1" : "rand_lat3", lat);
      if (cls_of(o, f) == C_SYS) begin
        if (lat == 1) do_halt($urandom_range(0, 4));
        else begin
          go = 1'b1;
          tick();
        end
      end
      go = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    out_t f0;
    isa[0]  = '{6'd0,  6'd0,  C_RALU, 4'd0,  1'b0, 1'b0, 1'b0};   // SLL
    isa[1]  = '{6'd0,  6'd2,  C_RALU, 4'd2,  1'b0, 1'b0, 1'b0};   // SRL
    isa[2]  = '{6'd0,  6'd3,  C_RALU, 4'd1,  1'b0, 1'b0, 1'b0};   // SRA
    isa[3]  = '{6'd0,  6'd4,  C_RALU, 4'd0,  1'b0, 1'b0, 1'b1};   // SLLV
    isa[4]  = '{6'd0,  6'd8,  C_JR,   4'd13, 1'b0, 1'b0, 1'b0};   // JR
    isa[5]  = '{6'd0,  6'd12, C_SYS,  4'd13, 1'b0, 1'b0, 1'b0};   // SYSCALL
    isa[6]  = '{6'd0,  6'd32, C_RALU, 4'd5,  1'b0, 1'b0, 1'b0};   // ADD
    isa[7]  = '{6'd0,  6'd33, C_RALU, 4'd5,  1'b0, 1'b0, 1'b0};   // ADDU
    isa[8]  = '{6'd0,  6'd34, C_RALU, 4'd6,  1'b0, 1'b0, 1'b0};   // SUB
    isa[9]  = '{6'd0,  6'd36, C_RALU, 4'd7,  1'b0, 1'b0, 1'b0};   // AND
    isa[10] = '{6'd0,  6'd37, C_RALU, 4'd8,  1'b0, 1'b0, 1'b0};   // OR
    isa[11] = '{6'd0,  6'd39, C_RALU, 4'd10, 1'b0, 1'b0, 1'b0};   // NOR
    isa[12] = '{6'd0,  6'd42, C_RALU, 4'd11, 1'b0, 1'b0, 1'b0};   // SLT
    isa[13] = '{6'd0,  6'd43, C_RALU, 4'd12, 1'b0, 1'b0, 1'b0};   // SLTU
    isa[14] = '{6'd2,  6'd0,  C_J,    4'd13, 1'b0, 1'b0, 1'b0};   // J
    isa[15] = '{6'd3,  6'd0,  C_JAL,  4'd13, 1'b0, 1'b0, 1'b0};   // JAL
    isa[16] = '{6'd4,  6'd0,  C_BEQ,  4'd13, 1'b0, 1'b0, 1'b0};   // BEQ
    isa[17] = '{6'd5,  6'd0,  C_BNE,  4'd13, 1'b0, 1'b0, 1'b0};   // BNE
    isa[18] = '{6'd7,  6'd0,  C_BGTZ, 4'd13, 1'b0, 1'b0, 1'b0};   // BGTZ
    isa[19] = '{6'd8,  6'd0,  C_IALU, 4'd5,  1'b1, 1'b1, 1'b0};   // ADDI
    isa[20] = '{6'd9,  6'd0,  C_IALU, 4'd5,  1'b1, 1'b1, 1'b0};   // ADDIU
    isa[21] = '{6'd10, 6'd0,  C_IALU, 4'd11, 1'b1, 1'b1, 1'b0};   // SLTI
    isa[22] = '{6'd11, 6'd0,  C_IALU, 4'd12, 1'b1, 1'b0, 1'b0};   // SLTIU
    isa[23] = '{6'd12, 6'd0,  C_IALU, 4'd7,  1'b1, 1'b0, 1'b0};   // ANDI
    isa[24] = '{6'd13, 6'd0,  C_IALU, 4'd8,  1'b1, 1'b0, 1'b0};   // ORI
    isa[25] = '{6'd35, 6'd0,  C_LW,   4'd5,  1'b1, 1'b1, 1'b0};   // LW
    isa[26] = '{6'd43, 6'd0,  C_SW,   4'd5,  1'b1, 1'b1, 1'b0};   // SW
    isa[27] = '{6'd41, 6'd0,  C_SH,   4'd5,  1'b1, 1'b1, 1'b0};   // SH

    //            op     func   eq    gtz  cyc alu    pcw   rw    mw    ill   mm
    vt[0]  = '{6'd0,  6'd32, 1'b0, 1'b0, 4, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0};  // ADD
    vt[1]  = '{6'd4,  6'd0,  1'b1, 1'b0, 3, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};  // BEQ taken
    vt[2]  = '{6'd4,  6'd0,  1'b0, 1'b1, 3, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};  // BEQ not
    vt[3]  = '{6'd5,  6'd0,  1'b0, 1'b0, 3, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};  // BNE taken
    vt[4]  = '{6'd5,  6'd0,  1'b1, 1'b1, 3, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};  // BNE not
    vt[5]  = '{6'd7,  6'd0,  1'b0, 1'b1, 3, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0};  // BGTZ taken
    vt[6]  = '{6'd7,  6'd0,  1'b1, 1'b0, 3, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};  // BGTZ not
    vt[7]  = '{6'd41, 6'd0,  1'b0, 1'b0, 4, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 2'd1};  // SH
    vt[8]  = '{6'd43, 6'd0,  1'b0, 1'b0, 4, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2};  // SW
    vt[9]  = '{6'd35, 6'd0,  1'b0, 1'b0, 5, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 2'd2};  // LW
    vt[10] = '{6'd2,  6'd0,  1'b0, 1'b0, 2, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0};  // J
    vt[11] = '{6'd3,  6'd0,  1'b0, 1'b0, 2, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0};  // JAL
    vt[12] = '{6'd0,  6'd8,  1'b0, 1'b0, 2, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0};  // JR
    vt[13] = '{6'd0,  6'd42, 1'b0, 1'b0, 4, 4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};  // SLT
    vt[14] = '{6'd13, 6'd0,  1'b0, 1'b0, 4, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0};  // ORI
    vt[15] = '{6'd0,  6'd3,  1'b0, 1'b0, 4, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0};  // SRA
    vt[16] = '{6'd63, 6'd0,  1'b0, 1'b0, 2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0};  // bad op
    vt[17] = '{6'd0,  6'd1,  1'b0, 1'b0, 2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0};  // bad func

    // reset held 3 cycles, then the first FETCH cycle
    do_reset(3);
    f0 = '0;
    f0.mem_read = 1'b1;
    f0.mem_mode = 2'b10;
    f0.ir_write = 1'b1;
    f0.pc_write = 1'b1;
    check("post_reset_fetch", obs_a, f0);

    // ADD traced cycle by cycle
    op = 6'd0; func = 6'd32; eq = 1'b0; gtz = 1'b0;
    build(op, func, eq, gtz, 1);
    run_trace("add_trace", 1);

    // table-driven vectors on MEM_LAT=1
    for (int i = 0; i < VEC_N; i++) run_count(vt[i], 1, $sformatf("vec%0d", i));

    // SYSCALL, 5 cycles parked, then resume
    op = 6'd0; func = 6'd12;
    build(op, func, 1'b0, 1'b0, 1);
    run_trace("syscall_trace", 1);
    do_halt(5);

    // reset in the middle of a store's MEM cycle
    op = 6'd43; func = 6'd0;
    tick(); tick(); tick();
    check("sw_mem_write_before_rst", 24'(obs_a.mem_write), 24'd1);
    check("sw_state_before_rst", 24'(obs_a.state), 24'd3);
    rst = 1'b1;
    #1;
    check("rst_in_mem_outs", obs_a, 24'd0);
    tick();
    check("rst_held_outs", obs_a, 24'd0);
    rst = 1'b0;
    #1;
    check("fetch_after_mid_rst", obs_a, f0);

    random_run(80, 1);

    // MEM_LAT=3 instance
    do_reset(2);
    run_count('{6'd35, 6'd0, 1'b0, 1'b0, 9, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2}, 3, "lw_lat3");
    op = 6'd41; func = 6'd0;
    build(op, func, 1'b0, 1'b0, 3);
    run_trace("sh_lat3_trace", 3);
    random_run(40, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
